// File: rtl/hht_pkg.sv
// Shared types and default widths for the HHT sparse-operand gather engine.
package hht_pkg;
  localparam int HHT_ADDR_W     = 32;
  localparam int HHT_DATA_W     = 32;
  localparam int HHT_CNT_W      = 16;
  localparam int HHT_FIFO_DEPTH = 8;
  localparam int HHT_STAGES     = 3;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3} hht_state_e;
  typedef enum logic {MODE_GATHER = 1'b0, MODE_LINEAR = 1'b1} hht_mode_e;
endpackage

// File: rtl/hht_sync_fifo.sv
// Output queue between the gather pipe and the CPU; power-of-2 depth, head reads 0 when empty.
module hht_sync_fifo
  import hht_pkg::*;
#(
  parameter int DEPTH = HHT_FIFO_DEPTH,
  parameter int WIDTH = HHT_DATA_W
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      cnt_q;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = empty_o ? '0 : mem_q[rd_q];
  assign count_o = cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end
endmodule

// File: rtl/hht_gather_engine.sv
// HHT gather engine: walks col[] on port A, gathers vec[v_base+idx] on port B, queues results.
// Optional bounds checking of gather indices is built when HHT_BOUNDS_CHECK_EN is defined.
module hht_gather_engine
  import hht_pkg::*;
#(
  parameter int ADDR_W     = HHT_ADDR_W,
  parameter int DATA_W     = HHT_DATA_W,
  parameter int CNT_W      = HHT_CNT_W,
  parameter int FIFO_DEPTH = HHT_FIFO_DEPTH
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              mode_i,
  input  logic [ADDR_W-1:0] col_base_i,
  input  logic [ADDR_W-1:0] v_base_i,
  input  logic [CNT_W-1:0]  count_i,
  input  logic [DATA_W-1:0] v_size_i,
  output logic              a_en_o,
  output logic [ADDR_W-1:0] a_addr_o,
  input  logic [DATA_W-1:0] a_rdata_i,
  output logic              b_en_o,
  output logic [ADDR_W-1:0] b_addr_o,
  input  logic [DATA_W-1:0] b_rdata_i,
  output logic              out_valid_o,
  output logic [DATA_W-1:0] out_data_o,
  input  logic              out_ready_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);
  hht_state_e        state_q, state_d;
  hht_mode_e         mode_q;
  logic [ADDR_W-1:0] col_base_q, v_base_q;
  logic [CNT_W-1:0]  cnt_q, iss_q;
  logic [DATA_W-1:0] idx_q;
  // vld_q[1]: port A data returning, [2]: idx held / port B read, [3]: port B data returning
  logic [HHT_STAGES:1] vld_q;
  logic              zero_q;
  logic              accept, issue, last_issue, credit_ok, oob, push;
  logic [DATA_W-1:0] push_data;
  logic [$clog2(FIFO_DEPTH):0] fifo_cnt;
  logic              fifo_empty, unused_full;

  assign accept     = (state_q == IDLE) && start_i;
  // Reserve a FIFO slot for every read in flight so the queue can never overflow.
  assign credit_ok  = (int'(fifo_cnt) + int'(vld_q[1]) + int'(vld_q[2]) + int'(vld_q[3])) < FIFO_DEPTH;
  assign issue      = (state_q == RUN) && credit_ok;
  assign last_issue = (iss_q == cnt_q - CNT_W'(1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = (count_i == '0) ? DONE : RUN;
      RUN:     if (issue && last_issue) state_d = DRAIN;
      DRAIN:   if (vld_q == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      mode_q     <= MODE_GATHER;
      col_base_q <= '0;
      v_base_q   <= '0;
      cnt_q      <= '0;
      iss_q      <= '0;
      idx_q      <= '0;
      vld_q      <= '0;
      zero_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        mode_q     <= hht_mode_e'(mode_i);
        col_base_q <= col_base_i;
        v_base_q   <= v_base_i;
        cnt_q      <= count_i;
        iss_q      <= '0;
      end else if (issue) begin
        iss_q <= iss_q + CNT_W'(1);
      end
      vld_q[1] <= issue;
      vld_q[2] <= vld_q[1] && (mode_q == MODE_GATHER);
      vld_q[3] <= vld_q[2];
      if (vld_q[1]) idx_q <= a_rdata_i;
      zero_q <= oob;
    end
  end

`ifdef HHT_BOUNDS_CHECK_EN
  logic [DATA_W-1:0] v_size_q;
  logic              err_q;

  assign oob   = vld_q[2] && (idx_q >= v_size_q);
  assign err_o = err_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      v_size_q <= '0;
      err_q    <= 1'b0;
    end else begin
      if (accept) begin
        v_size_q <= v_size_i;
        err_q    <= 1'b0;
      end
      if (oob) err_q <= 1'b1;
    end
  end
`else
  logic unused_vsize;

  assign oob          = 1'b0;
  assign err_o        = 1'b0;
  assign unused_vsize = ^v_size_i;
`endif

  assign a_en_o   = issue;
  assign a_addr_o = col_base_q + ADDR_W'(iss_q);
  assign b_en_o   = vld_q[2] && !oob;
  assign b_addr_o = v_base_q + ADDR_W'(idx_q);

  // Linear jobs push straight from port A; gather jobs push port B data, or 0 for a rejected index.
  assign push      = vld_q[3] || (vld_q[1] && (mode_q == MODE_LINEAR));
  assign push_data = vld_q[3] ? (zero_q ? '0 : b_rdata_i) : a_rdata_i;

  hht_sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_W)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .data_i  (push_data),
    .pop_i   (out_ready_i),
    .data_o  (out_data_o),
    .full_o  (unused_full),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

  assign out_valid_o = !fifo_empty;
  assign busy_o      = (state_q != IDLE);
  assign done_o      = (state_q == DONE);
endmodule
